// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 channel bundle between a burst master and the axi_burst_mem_slave endpoint.
// Clock and reset stay outside the bundle as plain module ports.
interface axi_burst_mem_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// AXI4 memory endpoint: independent write and read burst engines over a byte-lane word array,
// one outstanding transaction per direction, FIXED/INCR bursts, SLVERR for anything else.
module axi_burst_mem_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_burst_mem_slave_if.slave axi
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || ((32'd1 << size) > 32'(BYTES));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    return (burst == 2'b01) ? addr + (ADDR_WIDTH'(1) << size) : addr;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> LSB);
  endfunction

  logic                  run_reg;

  wstate_t               wstate_reg, wstate_next;
  logic [ID_WIDTH-1:0]   wid_reg, wid_next;
  logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
  logic [7:0]            wlen_reg, wlen_next;
  logic [2:0]            wsize_reg, wsize_next;
  logic [1:0]            wburst_reg, wburst_next;
  logic [7:0]            wcnt_reg, wcnt_next;
  logic                  werr_reg, werr_next;
  logic                  wcfg_err_reg, wcfg_err_next;
  logic                  mem_we;

  rstate_t               rstate_reg, rstate_next;
  logic [ID_WIDTH-1:0]   rid_reg, rid_next;
  logic [ADDR_WIDTH-1:0] raddr_reg, raddr_next;
  logic [7:0]            rlen_reg, rlen_next;
  logic [2:0]            rsize_reg, rsize_next;
  logic [1:0]            rburst_reg, rburst_next;
  logic [7:0]            rcnt_reg, rcnt_next;
  logic                  rerr_reg, rerr_next;
  logic                  rd_en;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // ready only rises once reset has been sampled released
  always_ff @(posedge aclk) begin
    if (!aresetn) run_reg <= 1'b0;
    else          run_reg <= 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate_reg   <= W_IDLE;
      wid_reg      <= '0;
      waddr_reg    <= '0;
      wlen_reg     <= '0;
      wsize_reg    <= '0;
      wburst_reg   <= '0;
      wcnt_reg     <= '0;
      werr_reg     <= 1'b0;
      wcfg_err_reg <= 1'b0;
    end else begin
      wstate_reg   <= wstate_next;
      wid_reg      <= wid_next;
      waddr_reg    <= waddr_next;
      wlen_reg     <= wlen_next;
      wsize_reg    <= wsize_next;
      wburst_reg   <= wburst_next;
      wcnt_reg     <= wcnt_next;
      werr_reg     <= werr_next;
      wcfg_err_reg <= wcfg_err_next;
    end
  end

  always_comb begin
    wstate_next   = wstate_reg;
    wid_next      = wid_reg;
    waddr_next    = waddr_reg;
    wlen_next     = wlen_reg;
    wsize_next    = wsize_reg;
    wburst_next   = wburst_reg;
    wcnt_next     = wcnt_reg;
    werr_next     = werr_reg;
    wcfg_err_next = wcfg_err_reg;
    mem_we        = 1'b0;
    case (wstate_reg)
      W_IDLE: begin
        if (axi.awvalid && run_reg) begin
          wid_next      = axi.awid;
          waddr_next    = axi.awaddr;
          wlen_next     = axi.awlen;
          wsize_next    = axi.awsize;
          wburst_next   = axi.awburst;
          wcnt_next     = '0;
          werr_next     = 1'b0;
          wcfg_err_next = burst_err(axi.awburst, axi.awsize);
          wstate_next   = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.wvalid) begin
          // a beat arriving on the reset edge belongs to an aborted burst
          mem_we = aresetn && !wcfg_err_reg;
          if (axi.wlast != (wcnt_reg == wlen_reg)) werr_next = 1'b1;
          if (wcnt_reg == wlen_reg) begin
            wstate_next = W_RESP;
          end else begin
            wcnt_next  = wcnt_reg + 8'd1;
            waddr_next = next_addr(waddr_reg, wsize_reg, wburst_reg);
          end
        end
      end
      W_RESP: begin
        if (axi.bready) wstate_next = W_IDLE;
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  assign axi.awready = run_reg && (wstate_reg == W_IDLE);
  assign axi.wready  = (wstate_reg == W_DATA);
  assign axi.bvalid  = (wstate_reg == W_RESP);
  assign axi.bid     = axi.bvalid ? wid_reg : '0;
  assign axi.bresp   = axi.bvalid ? {werr_reg | wcfg_err_reg, 1'b0} : 2'b00;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rstate_reg <= R_IDLE;
      rid_reg    <= '0;
      raddr_reg  <= '0;
      rlen_reg   <= '0;
      rsize_reg  <= '0;
      rburst_reg <= '0;
      rcnt_reg   <= '0;
      rerr_reg   <= 1'b0;
    end else begin
      rstate_reg <= rstate_next;
      rid_reg    <= rid_next;
      raddr_reg  <= raddr_next;
      rlen_reg   <= rlen_next;
      rsize_reg  <= rsize_next;
      rburst_reg <= rburst_next;
      rcnt_reg   <= rcnt_next;
      rerr_reg   <= rerr_next;
    end
  end

  // The word for the next beat is fetched on the handshake edge itself,
  // which gives a one-cycle first beat and bubble-free streaming.
  always_comb begin
    rstate_next = rstate_reg;
    rid_next    = rid_reg;
    raddr_next  = raddr_reg;
    rlen_next   = rlen_reg;
    rsize_next  = rsize_reg;
    rburst_next = rburst_reg;
    rcnt_next   = rcnt_reg;
    rerr_next   = rerr_reg;
    rd_en       = 1'b0;
    rd_idx      = word_idx(axi.araddr);
    case (rstate_reg)
      R_IDLE: begin
        if (axi.arvalid && run_reg) begin
          rid_next    = axi.arid;
          raddr_next  = axi.araddr;
          rlen_next   = axi.arlen;
          rsize_next  = axi.arsize;
          rburst_next = axi.arburst;
          rcnt_next   = '0;
          rerr_next   = burst_err(axi.arburst, axi.arsize);
          rd_en       = 1'b1;
          rstate_next = R_DATA;
        end
      end
      R_DATA: begin
        if (axi.rready) begin
          if (rcnt_reg == rlen_reg) begin
            rstate_next = R_IDLE;
          end else begin
            rcnt_next  = rcnt_reg + 8'd1;
            raddr_next = next_addr(raddr_reg, rsize_reg, rburst_reg);
            rd_en      = 1'b1;
            rd_idx     = word_idx(raddr_next);
          end
        end
      end
      default: rstate_next = R_IDLE;
    endcase
  end

  assign axi.arready = run_reg && (rstate_reg == R_IDLE);
  assign axi.rvalid  = (rstate_reg == R_DATA);
  assign axi.rdata   = (axi.rvalid && !rerr_reg) ? rd_word : '0;
  assign axi.rid     = axi.rvalid ? rid_reg : '0;
  assign axi.rresp   = axi.rvalid ? {rerr_reg, 1'b0} : 2'b00;
  assign axi.rlast   = axi.rvalid && (rcnt_reg == rlen_reg);

  // One byte-wide array per lane; read-before-write gives old data on a same-word collision.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_WORDS];
    logic [7:0] rd_byte_reg;

    always_ff @(posedge aclk) begin
      if (mem_we && axi.wstrb[gi]) lane_mem[word_idx(waddr_reg)] <= axi.wdata[gi*8 +: 8];
      if (rd_en) rd_byte_reg <= lane_mem[rd_idx];
    end

    assign rd_word[gi*8 +: 8] = rd_byte_reg;
  end
endmodule
